// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the mem_ctrl port arbiter.
package ez8_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DMA  = 1'b1
    } owner_t;

    localparam logic [7:0] STATUS_ADDR = 8'h01;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between CORE, DMA, the arbiter and the mem_ctrl port.
interface mem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          core_req;
    logic          core_we;
    logic          core_lock;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_gnt;
    logic          core_rvalid;
    logic [DW-1:0] core_rdata;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [DW-1:0] dma_rdata;
    logic          dma_err;

    logic [AW-1:0] mem_writeaddr;
    logic [DW-1:0] mem_writedata;
    logic          mem_write_en;
    logic [AW-1:0] mem_readaddr;
    logic [DW-1:0] mem_readdata;

    modport slave (
        input  core_req, core_we, core_lock, core_addr, core_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_readdata,
        output core_gnt, core_rvalid, core_rdata,
        output dma_gnt, dma_rvalid, dma_rdata, dma_err,
        output mem_writeaddr, mem_writedata, mem_write_en, mem_readaddr
    );

    modport master (
        output core_req, core_we, core_lock, core_addr, core_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_readdata,
        input  core_gnt, core_rvalid, core_rdata,
        input  dma_gnt, dma_rvalid, dma_rdata, dma_err,
        input  mem_writeaddr, mem_writedata, mem_write_en, mem_readaddr
    );

endinterface

// File: rtl/mem_arbiter_pick.sv
// Combinational CORE/DMA winner select: lock first, then starvation guard or round-robin.
// MEM_ARB_RR_EN selects round-robin on contention; otherwise fixed priority with starvation counter.
module mem_arb_pick
    import ez8_mem_pkg::*;
#(
    parameter int CW     = 3,
    parameter int STARVE = 4
) (
    input  logic          i_arb_en,
    input  logic          i_core_req,
    input  logic          i_dma_req,
    input  logic          i_lock,
`ifdef MEM_ARB_RR_EN
    input  owner_t        i_last,
`else
    input  logic [CW-1:0] i_cnt,
`endif
    output logic          o_core_gnt,
    output logic          o_dma_gnt
);

    always_comb begin
        o_core_gnt = 1'b0;
        o_dma_gnt  = 1'b0;
        if (i_arb_en) begin
            if (i_lock) begin
                o_core_gnt = i_core_req;
            end else if (i_core_req && i_dma_req) begin
`ifdef MEM_ARB_RR_EN
                if (i_last == OWN_CORE) o_dma_gnt = 1'b1;
                else                    o_core_gnt = 1'b1;
`else
                if (i_cnt == CW'(STARVE)) o_dma_gnt = 1'b1;
                else                      o_core_gnt = 1'b1;
`endif
            end else begin
                o_core_gnt = i_core_req;
                o_dma_gnt  = i_dma_req;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single mem_ctrl port between CORE and DMA: grant -> issue -> response, one access per 2 cycles.
// MEM_ARB_RR_EN selects round-robin arbitration; default is fixed CORE priority with DMA starvation guard.
module mem_arbiter
    import ez8_mem_pkg::*;
#(
    parameter int            AW       = 8,
    parameter int            DW       = 8,
    parameter logic [AW-1:0] STATUS_A = AW'(STATUS_ADDR),
    parameter int            STARVE   = 4
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    localparam int CW = $clog2(STARVE + 1);

    // IDLE: wait for request | ISSUE: drive mem port | RESP: return read data, may re-arbitrate
    arb_state_t    r_state, w_state_next;
    owner_t        r_owner;
    logic          r_we, r_blocked, r_lock;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata, r_core_rdata, r_dma_rdata;
    logic          w_arb_en, w_core_gnt, w_dma_gnt, w_any_gnt;
    logic          w_core_rd_resp, w_dma_rd_resp;

    assign w_arb_en  = (r_state == IDLE) || (r_state == RESP);
    assign w_any_gnt = w_core_gnt || w_dma_gnt;

`ifdef MEM_ARB_RR_EN
    owner_t r_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          r_last <= OWN_DMA;
        else if (w_any_gnt) r_last <= w_core_gnt ? OWN_CORE : OWN_DMA;
    end
`else
    logic [CW-1:0] r_starve_cnt;

    // Saturates while the lock keeps DMA out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_starve_cnt <= '0;
        else if (!bus.dma_req || w_dma_gnt)
            r_starve_cnt <= '0;
        else if (w_core_gnt && (r_starve_cnt != CW'(STARVE)))
            r_starve_cnt <= r_starve_cnt + CW'(1);
    end
`endif

    mem_arb_pick #(.CW(CW), .STARVE(STARVE)) u_pick (
        .i_arb_en   (w_arb_en),
        .i_core_req (bus.core_req),
        .i_dma_req  (bus.dma_req),
        .i_lock     (r_lock),
`ifdef MEM_ARB_RR_EN
        .i_last     (r_last),
`else
        .i_cnt      (r_starve_cnt),
`endif
        .o_core_gnt (w_core_gnt),
        .o_dma_gnt  (w_dma_gnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_any_gnt) w_state_next = ISSUE;
            ISSUE:   w_state_next = RESP;
            RESP:    w_state_next = w_any_gnt ? ISSUE : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner      <= OWN_CORE;
            r_we         <= 1'b0;
            r_blocked    <= 1'b0;
            r_lock       <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_core_rdata <= '0;
            r_dma_rdata  <= '0;
        end else begin
            if (w_core_gnt) begin
                r_owner   <= OWN_CORE;
                r_we      <= bus.core_we;
                r_blocked <= 1'b0;
                r_addr    <= bus.core_addr;
                r_wdata   <= bus.core_wdata;
                r_lock    <= bus.core_lock;
            end else if (w_dma_gnt) begin
                r_owner   <= OWN_DMA;
                r_we      <= bus.dma_we;
                r_blocked <= bus.dma_we && (bus.dma_addr == STATUS_A);
                r_addr    <= bus.dma_addr;
                r_wdata   <= bus.dma_wdata;
            end
            if (w_core_rd_resp) r_core_rdata <= bus.mem_readdata;
            if (w_dma_rd_resp)  r_dma_rdata  <= bus.mem_readdata;
        end
    end

    // Read data is forwarded in RESP so rvalid lands two cycles after the grant.
    assign w_core_rd_resp = (r_state == RESP) && (r_owner == OWN_CORE) && !r_we;
    assign w_dma_rd_resp  = (r_state == RESP) && (r_owner == OWN_DMA) && !r_we;

    assign bus.core_gnt      = w_core_gnt;
    assign bus.dma_gnt       = w_dma_gnt;
    assign bus.core_rvalid   = w_core_rd_resp;
    assign bus.dma_rvalid    = w_dma_rd_resp;
    assign bus.core_rdata    = w_core_rd_resp ? bus.mem_readdata : r_core_rdata;
    assign bus.dma_rdata     = w_dma_rd_resp  ? bus.mem_readdata : r_dma_rdata;
    assign bus.dma_err       = (r_state == RESP) && r_blocked;
    assign bus.mem_writeaddr = r_addr;
    assign bus.mem_readaddr  = r_addr;
    assign bus.mem_writedata = r_wdata;
    assign bus.mem_write_en  = (r_state == ISSUE) && r_we && !r_blocked;

endmodule
